// File: rtl/comandos_pkg.sv
// Shared constants, state type and range-compare helper for the command sequencer.
package comandos_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PESO_W = 7;
  localparam int unsigned POS_W  = 2;

  localparam logic [BYTE_W-1:0] CMD_CONFIG  = 8'h30;
  localparam logic [BYTE_W-1:0] CMD_ATUAL   = 8'h31;
  localparam logic [BYTE_W-1:0] CMD_DESLIGA = 8'h32;
  localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_NOVE  = 8'h39;

  localparam logic [POS_W-1:0] POS_ABAIXO    = 2'd0;
  localparam logic [POS_W-1:0] POS_FAIXA     = 2'd1;
  localparam logic [POS_W-1:0] POS_ACIMA     = 2'd2;
  localparam logic [POS_W-1:0] POS_DESLIGADO = 2'd3;

  typedef enum logic [1:0] {
    ESPERA_CMD    = 2'd0,
    RECEBE_DIGITO = 2'd1,
    VALIDA        = 2'd2,
    APLICA        = 2'd3
  } estado_t;

  // Position of a weight against an inclusive [min, max] window.
  function automatic logic [POS_W-1:0] calc_posicao(input logic [PESO_W-1:0] atual,
                                                    input logic [PESO_W-1:0] pmin,
                                                    input logic [PESO_W-1:0] pmax);
    if (atual < pmin)      return POS_ABAIXO;
    else if (atual > pmax) return POS_ACIMA;
    else                   return POS_FAIXA;
  endfunction

endpackage

// File: rtl/sequenciador_comandos_if.sv
// Byte stream from the UART receiver: data plus one-cycle valid strobe.
interface sequenciador_comandos_if;
  logic [7:0] dado_recebido;
  logic       pronto_recebimento;

  modport master (output dado_recebido, output pronto_recebimento);
  modport slave  (input  dado_recebido, input  pronto_recebimento);
endinterface

// File: rtl/sequenciador_comandos_contador_timeout.sv
// Inter-byte timeout counter: cleared on every byte, counts while a frame is open.
module contador_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_limpa,
  input  logic i_habilita,
  output logic o_estouro_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  logic [CNT_W-1:0] r_contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_contagem <= '0;
    else if (i_limpa)    r_contagem <= '0;
    else if (i_habilita) r_contagem <= r_contagem + CNT_W'(1);
  end

  assign o_estouro_c = i_habilita && (r_contagem == CNT_W'(TIMEOUT_CICLOS - 1));

endmodule

// File: rtl/sequenciador_comandos.sv
// Parses ASCII command frames into min/max/current weights and drives the PWM position select.
module sequenciador_comandos
  import comandos_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 1_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  sequenciador_comandos_if.slave   rx,
  output logic [PESO_W-1:0]        peso_min,
  output logic [PESO_W-1:0]        peso_max,
  output logic [PESO_W-1:0]        peso_atual,
  output logic [POS_W-1:0]         posicao_pwm,
  output logic                     atualizado,
  output logic                     erro,
  output logic                     ocupado
);

  estado_t           r_estado, w_prox_estado;
  logic [BYTE_W-1:0] r_cmd;
  logic [2:0]        r_idx;
  logic [3:0]        r_dezena;
  logic [PESO_W-1:0] r_sh_min, r_sh_max, r_sh_atual;
  logic [PESO_W-1:0] r_peso_min, r_peso_max, r_peso_atual;
  logic [POS_W-1:0]  r_posicao;
  logic              r_atualizado, r_erro, r_ocupado;

  logic              w_strobe, w_eh_digito, w_cmd_valido, w_ultimo, w_estouro, w_min_maior;
  logic [BYTE_W-1:0] w_byte;
  logic [3:0]        w_digito;
  logic [PESO_W-1:0] w_valor;

  assign w_strobe     = rx.pronto_recebimento;
  assign w_byte       = rx.dado_recebido;
  assign w_eh_digito  = (w_byte >= ASCII_ZERO) && (w_byte <= ASCII_NOVE);
  assign w_digito     = 4'(w_byte - ASCII_ZERO);
  assign w_valor      = PESO_W'(r_dezena) * PESO_W'(10) + PESO_W'(w_digito);
  assign w_cmd_valido = (w_byte == CMD_CONFIG) || (w_byte == CMD_ATUAL) || (w_byte == CMD_DESLIGA);
  assign w_ultimo     = (r_idx == ((r_cmd == CMD_CONFIG) ? 3'd5 : 3'd1));
  assign w_min_maior  = (r_cmd == CMD_CONFIG) && (r_sh_min > r_sh_max);

  contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_timeout (
    .clock       (clock),
    .reset       (reset),
    .i_limpa     (w_strobe),
    .i_habilita  (r_estado == RECEBE_DIGITO),
    .o_estouro_c (w_estouro)
  );

  // Next-state decode; a byte always wins over a simultaneous timeout.
  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      ESPERA_CMD: begin
        if (w_strobe && w_cmd_valido)
          w_prox_estado = (w_byte == CMD_DESLIGA) ? VALIDA : RECEBE_DIGITO;
      end
      RECEBE_DIGITO: begin
        if (w_strobe) begin
          if (!w_eh_digito)  w_prox_estado = ESPERA_CMD;
          else if (w_ultimo) w_prox_estado = VALIDA;
        end else if (w_estouro) begin
          w_prox_estado = ESPERA_CMD;
        end
      end
      VALIDA:  w_prox_estado = w_min_maior ? ESPERA_CMD : APLICA;
      APLICA:  w_prox_estado = ESPERA_CMD;
      default: w_prox_estado = ESPERA_CMD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= ESPERA_CMD;
      r_cmd        <= '0;
      r_idx        <= '0;
      r_dezena     <= '0;
      r_sh_min     <= '0;
      r_sh_max     <= '0;
      r_sh_atual   <= '0;
      r_peso_min   <= '0;
      r_peso_max   <= PESO_W'(99);
      r_peso_atual <= '0;
      r_posicao    <= POS_DESLIGADO;
      r_atualizado <= 1'b0;
      r_erro       <= 1'b0;
      r_ocupado    <= 1'b0;
    end else begin
      r_estado     <= w_prox_estado;
      r_ocupado    <= (w_prox_estado != ESPERA_CMD);
      r_atualizado <= 1'b0;
      case (r_estado)
        ESPERA_CMD: begin
          if (w_strobe) begin
            if (w_cmd_valido) begin
              r_cmd  <= w_byte;
              r_idx  <= '0;
              r_erro <= 1'b0;
            end else begin
              r_erro <= 1'b1;
            end
          end
        end
        RECEBE_DIGITO: begin
          if (w_strobe) begin
            if (!w_eh_digito) begin
              r_erro <= 1'b1;
            end else begin
              r_idx <= r_idx + 3'd1;
              // Even index carries the tens digit; odd index completes a value.
              if (!r_idx[0])                                r_dezena   <= w_digito;
              else if (r_cmd == CMD_ATUAL || r_idx == 3'd5) r_sh_atual <= w_valor;
              else if (r_idx == 3'd1)                       r_sh_min   <= w_valor;
              else                                          r_sh_max   <= w_valor;
            end
          end else if (w_estouro) begin
            r_erro <= 1'b1;
          end
        end
        VALIDA: begin
          if (w_min_maior) r_erro <= 1'b1;
        end
        APLICA: begin
          r_atualizado <= 1'b1;
          if (r_cmd == CMD_CONFIG) begin
            r_peso_min   <= r_sh_min;
            r_peso_max   <= r_sh_max;
            r_peso_atual <= r_sh_atual;
            r_posicao    <= calc_posicao(r_sh_atual, r_sh_min, r_sh_max);
          end else if (r_cmd == CMD_ATUAL) begin
            r_peso_atual <= r_sh_atual;
            r_posicao    <= calc_posicao(r_sh_atual, r_peso_min, r_peso_max);
          end else begin
            r_posicao    <= POS_DESLIGADO;
          end
        end
        default: ;
      endcase
    end
  end

  assign peso_min    = r_peso_min;
  assign peso_max    = r_peso_max;
  assign peso_atual  = r_peso_atual;
  assign posicao_pwm = r_posicao;
  assign atualizado  = r_atualizado;
  assign erro        = r_erro;
  assign ocupado     = r_ocupado;

endmodule

// File: tb/tb_sequenciador_comandos.sv
// Directed-vector bench for sequenciador_comandos with hand-computed expectations.
module tb_sequenciador_comandos;

  localparam int unsigned TMO = 1000;

  typedef logic [7:0] bytes_t [7];

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] peso_min, peso_max, peso_atual;
  logic [1:0] posicao_pwm;
  logic       atualizado, erro, ocupado;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulsos = 0;
  int base     = 0;
  bytes_t q;

  always #5 clock = ~clock;

  sequenciador_comandos_if u_rx ();

  sequenciador_comandos #(.TIMEOUT_CICLOS(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (u_rx),
    .peso_min    (peso_min),
    .peso_max    (peso_max),
    .peso_atual  (peso_atual),
    .posicao_pwm (posicao_pwm),
    .atualizado  (atualizado),
    .erro        (erro),
    .ocupado     (ocupado)
  );

  // Running count of update pulses; frames compare against a snapshot.
  always @(negedge clock) if (atualizado) n_pulsos++;

  task automatic verifica(input string tag, input int obs, input int esp);
    n_checks++;
    if (obs == esp) n_pass++;
    else $display("FAIL %s: obtido %0d esperado %0d", tag, obs, esp);
  endtask

  task automatic verifica_saidas(input string tag, input int pmin, input int pmax,
                                 input int patual, input int pos, input int perro);
    verifica({tag, ".min"},   int'(peso_min),    pmin);
    verifica({tag, ".max"},   int'(peso_max),    pmax);
    verifica({tag, ".atual"}, int'(peso_atual),  patual);
    verifica({tag, ".pos"},   int'(posicao_pwm), pos);
    verifica({tag, ".erro"},  int'(erro),        perro);
  endtask

  task automatic verifica_reset(input string tag);
    verifica_saidas(tag, 0, 99, 0, 3, 0);
    verifica({tag, ".atualizado"}, int'(atualizado), 0);
    verifica({tag, ".ocupado"},    int'(ocupado),    0);
  endtask

  task automatic ciclos(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Byte is consumed on the next rising edge; returns 1 time unit after it.
  task automatic envia(input logic [7:0] b);
    u_rx.dado_recebido      = b;
    u_rx.pronto_recebimento = 1'b1;
    @(posedge clock);
    #1;
    u_rx.pronto_recebimento = 1'b0;
  endtask

  task automatic quadro(input bytes_t b, input int n, input int gap);
    base = n_pulsos;
    for (int i = 0; i < n; i++) begin
      envia(b[i]);
      if (i < n - 1) ciclos(gap);
    end
    ciclos(6);
  endtask

  initial begin
    u_rx.dado_recebido      = 8'h00;
    u_rx.pronto_recebimento = 1'b0;
    ciclos(3);
    verifica_reset("reset");
    reset = 1'b1;
    ciclos(2);

    // Full configuration 10/20/15 with exact latency tracking
    q = '{8'h30, 8'h31, 8'h30, 8'h32, 8'h30, 8'h31, 8'h35};
    base = n_pulsos;
    for (int i = 0; i < 7; i++) begin
      envia(q[i]);
      if (i < 6) ciclos(2);
    end
    verifica("cfg.ocupado_k", int'(ocupado), 1);
    ciclos(1);
    verifica("cfg.atualizado_k1", int'(atualizado), 0);
    ciclos(1);
    verifica("cfg.atualizado_k2", int'(atualizado), 1);
    verifica_saidas("cfg", 10, 20, 15, 1, 0);
    verifica("cfg.ocupado_k2", int'(ocupado), 0);
    ciclos(1);
    verifica("cfg.atualizado_k3", int'(atualizado), 0);
    ciclos(3);
    verifica("cfg.pulsos", n_pulsos - base, 1);

    q = '{8'h31, 8'h32, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
    quadro(q, 3, 2);
    verifica_saidas("atual25", 10, 20, 25, 2, 0);
    verifica("atual25.pulsos", n_pulsos - base, 1);

    q = '{8'h31, 8'h30, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
    quadro(q, 3, 2);
    verifica_saidas("atual05", 10, 20, 5, 0, 0);

    // min 20 > max 10: rejected, outputs held
    q = '{8'h30, 8'h32, 8'h30, 8'h31, 8'h30, 8'h31, 8'h35};
    quadro(q, 7, 2);
    verifica_saidas("minmax", 10, 20, 5, 0, 1);
    verifica("minmax.pulsos", n_pulsos - base, 0);

    // Non-digit aborts the frame
    q = '{8'h30, 8'h31, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00};
    quadro(q, 3, 2);
    verifica_saidas("digA", 10, 20, 5, 0, 1);
    verifica("digA.ocupado", int'(ocupado), 0);
    verifica("digA.pulsos", n_pulsos - base, 0);

    base = n_pulsos;
    envia(8'h32);
    verifica("desliga.erro_limpo", int'(erro), 0);
    ciclos(6);
    verifica_saidas("desliga", 10, 20, 5, 3, 0);
    verifica("desliga.pulsos", n_pulsos - base, 1);

    // Back-to-back strobes, re-enable from disabled
    q = '{8'h31, 8'h34, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00};
    quadro(q, 3, 0);
    verifica_saidas("b2b", 10, 20, 42, 2, 0);
    verifica("b2b.pulsos", n_pulsos - base, 1);

    // min == max is legal and inclusive
    q = '{8'h30, 8'h35, 8'h30, 8'h35, 8'h30, 8'h35, 8'h30};
    quadro(q, 7, 1);
    verifica_saidas("igual", 50, 50, 50, 1, 0);

    envia(8'h5A);
    verifica("cmd_invalido.erro", int'(erro), 1);
    verifica("cmd_invalido.ocupado", int'(ocupado), 0);
    ciclos(2);

    // Timeout: erro exactly TMO clocks after the last strobe
    envia(8'h30);
    ciclos(2);
    envia(8'h31);
    verifica("tmo.erro_limpo", int'(erro), 0);
    ciclos(TMO - 1);
    verifica("tmo.erro_antes", int'(erro), 0);
    verifica("tmo.ocupado_antes", int'(ocupado), 1);
    ciclos(1);
    verifica("tmo.erro", int'(erro), 1);
    verifica("tmo.ocupado", int'(ocupado), 0);
    verifica_saidas("tmo", 50, 50, 50, 1, 1);

    // Asynchronous reset in the middle of a frame
    envia(8'h30); ciclos(2);
    envia(8'h31); ciclos(2);
    envia(8'h30); ciclos(2);
    envia(8'h32);
    #2 reset = 1'b0;
    #1;
    verifica_reset("reset_meio");
    ciclos(2);
    reset = 1'b1;
    ciclos(2);

    q = '{8'h30, 8'h30, 8'h35, 8'h39, 8'h39, 8'h30, 8'h37};
    quadro(q, 7, 2);
    verifica_saidas("pos_reset", 5, 99, 7, 1, 0);
    verifica("pos_reset.pulsos", n_pulsos - base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
